sobol_stream_decoder: RTL and testbench
=======================================

Name: sobol_stream_decoder

Overview:
- Stochastic-to-binary converter: the receive end of the Sobol-based unary bitstream path.
- A Sobol generator plus comparator encodes a binary value as a bitstream. This block counts ones over a fixed window of 2^BITWIDTH sampled bits and returns the binary value.
- Sits downstream of stochastic arithmetic; results are handed to binary-domain logic through a one-cycle valid pulse.

Parameters:
- BITWIDTH, 8, binary resolution; window length N = 2^BITWIDTH sampled bits.

Ports:
- iClk  input  1  clock
- iRst  input  1  asynchronous reset, active-high
- iSel  input  1  sample enable; iBit is counted only in cycles with iSel=1 in ACCUM (same qualifier as the generator's advance enable)
- iClr  input  1  synchronous clear, abort and return to IDLE
- iStart  input  1  start a new decode window
- iBit  input  1  stochastic bitstream input
- oValue  output  BITWIDTH+1  decoded value (count of ones, 0..N)
- oValid  output  1  one-cycle pulse: oValue updated
- oBusy  output  1  high while in ACCUM

Behaviour:
- Reset (iRst=1, asynchronous):
  - state=IDLE; onesCnt=0; smpCnt=0; oValue=0; oValid=0; oBusy=0.
  - Effective immediately, mid-window included.
- Internal registers:
  - onesCnt, BITWIDTH+1 bits.
  - smpCnt, BITWIDTH bits.
- States: IDLE, ACCUM. oBusy = (state==ACCUM), registered.
- IDLE:
  - iStart=1 -> ACCUM next edge; onesCnt and smpCnt cleared at that edge.
  - iBit is not sampled in the start cycle.
  - oValue holds its last result.
- ACCUM, each edge with iSel=1:
  - onesCnt += iBit; smpCnt += 1.
  - iSel=0: no change, no timeout.
- Window end (sample taken with smpCnt==N-1):
  - Same edge: oValue <= onesCnt + iBit; oValid <= 1 for exactly one cycle; state <= IDLE.
  - smpCnt wraps to 0.
  - Latency: oValid is high in the cycle after the N-th qualified sample.
- iStart in ACCUM: ignored; the window is not restarted and no error is flagged.
- iStart during the oValid cycle (state already IDLE): accepted; back-to-back windows with one dead cycle.
- iClr=1 (any state; priority over iStart and sampling):
  - state=IDLE; counters=0; oValue=0; oValid=0 next edge.
  - An in-progress window is discarded with no oValid.
- Arithmetic:
  - Unsigned, no saturation.
  - All-ones window yields N (needs the extra MSB); all-zeros yields 0.
  - For a comparator stream of input X against a full Sobol period: oValue == X exactly.
- oValid is never asserted in two consecutive cycles.

Optional Feature:
- Macro: SOBOL_DECODER_BIPOLAR_EN.
- Defined:
  - oValue is two's-complement signed, BITWIDTH+1 bits: onesCnt_final - N/2, range -N/2..+N/2.
  - Represents bipolar stochastic value (2p-1) scaled by N/2.
  - Reset/clear value is still 0.
- Undefined: unsigned count as above.
- Timing, handshake and state machine are identical in both builds.

Test Plan:
- All parameters default (BITWIDTH=8, N=256); unsigned build unless stated.
- Start pulse, then 256 cycles iSel=1, iBit=1 -> oValid single pulse on cycle 257 after start+1; oValue=256; oBusy falls with it.
- Drive iBit from the comparator (iIn=100 vs 8-bit Sobol, same iSel) for one full window -> oValue=100. Repeat with iIn=0 -> 0 and iIn=255 -> 255.
- Alternating iBit with iSel toggling 1/0 every cycle (512 cycles), plus iStart re-pulsed mid-window -> completes after 256 qualified samples only; oValue=128; re-start ignored.
- iClr asserted after 50 samples -> next cycle oBusy=0, oValue=0, no oValid. New start with 256 zeros -> oValue=0, oValid once.
- iRst asserted asynchronously mid-window (between edges) -> oBusy/oValid/oValue read 0 before next edge. Start after release -> normal window.
- SOBOL_DECODER_BIPOLAR_EN defined:
  - 64 ones in window -> oValue=-64 (9'h1C0).
  - 256 ones -> +128 (9'h080).
  - Back-to-back start in oValid cycle -> second window accepted.

Source files
------------

// File: rtl/sobol_stream_decoder.sv
// Purpose: stochastic-to-binary decoder; counts ones over 2**BITWIDTH qualified samples of a bitstream.
// Latency: oValid pulses for one cycle in the cycle after the N-th qualified (iSel=1) sample.
// Backpressure: none; iSel=0 stalls accumulation, iStart is ignored while a window is in progress.
// Build option: define SOBOL_DECODER_BIPOLAR_EN to report the result as signed (count - N/2).
module sobol_stream_decoder #(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iSel,
    input  logic                iClr,
    input  logic                iStart,
    input  logic                iBit,
    output logic [BITWIDTH:0]   oValue,
    output logic                oValid,
    output logic                oBusy
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Index of the last sample in a window (N-1).
    localparam logic [BITWIDTH-1:0] SMP_LAST = '1;
    // N/2, used as the bipolar offset.
    localparam logic [BITWIDTH:0]   HALF     = {2'b01, {(BITWIDTH-1){1'b0}}};

    state_t              state;
    logic [BITWIDTH:0]   ones_cnt;
    logic [BITWIDTH-1:0] smp_cnt;
    logic [BITWIDTH:0]   ones_next;
    logic [BITWIDTH:0]   result;
    logic                window_end;

    // Running count including the bit sampled this cycle; the extra MSB holds an all-ones window.
    assign ones_next  = ones_cnt + {{BITWIDTH{1'b0}}, iBit};
    assign window_end = (smp_cnt == SMP_LAST);

`ifdef SOBOL_DECODER_BIPOLAR_EN
    // Bipolar view: two's-complement count - N/2, range -N/2..+N/2.
    assign result = ones_next - HALF;
`else
    // Unipolar view: plain count of ones, 0..N.
    assign result = ones_next;
`endif

    // Window control FSM with registered outputs; clear has priority over start and sampling.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state    <= IDLE;
            ones_cnt <= '0;
            smp_cnt  <= '0;
            oValue   <= '0;
            oValid   <= 1'b0;
            oBusy    <= 1'b0;
        end else begin
            oValid <= 1'b0;
            if (iClr) begin
                state    <= IDLE;
                ones_cnt <= '0;
                smp_cnt  <= '0;
                oValue   <= '0;
                oBusy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (iStart) begin
                            state    <= ACCUM;
                            oBusy    <= 1'b1;
                            ones_cnt <= '0;
                            smp_cnt  <= '0;
                        end
                    end
                    ACCUM: begin
                        if (iSel) begin
                            ones_cnt <= ones_next;
                            smp_cnt  <= smp_cnt + 1'b1;
                            if (window_end) begin
                                oValue <= result;
                                oValid <= 1'b1;
                                oBusy  <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        oBusy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sobol_stream_decoder.sv
// Self-checking bench for sobol_stream_decoder (BITWIDTH=8, N=256).
// Table-driven windows, comparator streams against a bit-reversal Sobol sequence,
// randomized windows against a sample-list model, plus clear/reset/back-to-back sequences.
module tb_sobol_stream_decoder;

    localparam int N = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       clr;
    logic       start;
    logic       bitin;
    logic [8:0] value;
    logic       valid;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    sobol_stream_decoder #(.BITWIDTH(8)) dut (
        .iClk   (clk),
        .iRst   (rst),
        .iSel   (sel),
        .iClr   (clr),
        .iStart (start),
        .iBit   (bitin),
        .oValue (value),
        .oValid (valid),
        .oBusy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    kind;    // 0: first X samples are ones, 1: comparator X vs Sobol
        int    x;
        int    exp_cnt; // expected count of ones in the window
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Map a count of ones to the value the build under test reports.
    function automatic logic [8:0] to_out(input int cnt);
`ifdef SOBOL_DECODER_BIPOLAR_EN
        return 9'(cnt - N / 2);
`else
        return 9'(cnt);
`endif
    endfunction

    // First Sobol dimension for an 8-bit period: bit-reversed index.
    function automatic logic [7:0] sobol8(input int idx);
        logic [7:0] k;
        logic [7:0] r;
        k = 8'(idx);
        for (int i = 0; i < 8; i++) r[i] = k[7-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a window and feed 256 qualified samples from bits[]; mode 0: iSel always 1,
    // mode 1: iSel toggles with a re-start mid-window, mode 2: random iSel and random re-starts.
    task automatic run_window(input string name, input logic [255:0] bits, input int mode,
                              input int exp_cnt, input bit back2back);
        int k;
        int cyc;
        int early;
        bit s;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_busy_at_start"}, 9'(busy), 9'd1);
        check({name, "_no_valid_at_start"}, 9'(valid), 9'd0);
        k = 0;
        cyc = 0;
        early = 0;
        while (k < N && cyc < 4 * N) begin
            case (mode)
                0:       s = 1'b1;
                1:       s = (cyc % 2 == 0);
                default: s = 1'($urandom_range(0, 1));
            endcase
            sel   = s;
            bitin = s ? bits[k] : 1'($urandom);
            start = (mode == 1 && cyc == 101) || (mode == 2 && $urandom_range(0, 40) == 0);
            if (s) k++;
            tick();
            cyc++;
            if (k < N && valid) early++;
        end
        start = 1'b0;
        sel   = 1'b0;
        check({name, "_no_early_valid"}, 9'(early), 9'd0);
        check({name, "_valid"}, 9'(valid), 9'd1);
        check({name, "_value"}, value, to_out(exp_cnt));
        check({name, "_busy_falls"}, 9'(busy), 9'd0);
        if (mode == 0) check({name, "_latency"}, 9'(cyc), 9'(N));
        if (!back2back) begin
            tick();
            check({name, "_single_pulse"}, 9'(valid), 9'd0);
            check({name, "_value_hold"}, value, to_out(exp_cnt));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] bits;
        int pulses;

        tbl[0] = '{"all_ones",  0, 256, 256};
        tbl[1] = '{"all_zeros", 0, 0,   0};
        tbl[2] = '{"ones64",    0, 64,  64};
        tbl[3] = '{"sobol100",  1, 100, 100};
        tbl[4] = '{"sobol0",    1, 0,   0};
        tbl[5] = '{"sobol255",  1, 255, 255};
        tbl[6] = '{"sobol1",    1, 1,   1};

        rst = 1'b1; sel = 1'b0; clr = 1'b0; start = 1'b0; bitin = 1'b0;
        #2;
        check("reset_value", value, 9'd0);
        check("reset_valid", 9'(valid), 9'd0);
        check("reset_busy", 9'(busy), 9'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Table-driven windows
        for (int t = 0; t < 7; t++) begin
            for (int k = 0; k < N; k++)
                bits[k] = (tbl[t].kind == 0) ? (k < tbl[t].x) : (int'(sobol8(k)) < tbl[t].x);
            run_window(tbl[t].name, bits, 0, tbl[t].exp_cnt, 1'b0);
        end

        // Alternating bits, iSel toggling, re-start mid-window ignored
        for (int k = 0; k < N; k++) bits[k] = (k % 2 == 0);
        run_window("alt_sel_toggle", bits, 1, 128, 1'b0);

        // Randomized windows against the sample-list model
        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 8; w++) bits[w*32 +: 32] = $urandom;
            run_window($sformatf("rand%0d", r), bits, 2, $countones(bits), 1'b0);
        end

        // Clear after 50 samples discards the window
        bits = '1;
        run_window("pre_clear", bits, 0, 256, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        sel = 1'b1; bitin = 1'b1;
        repeat (50) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clear_busy", 9'(busy), 9'd0);
        check("clear_value", value, 9'd0);
        check("clear_valid", 9'(valid), 9'd0);
        pulses = 0;
        repeat (300) begin
            tick();
            if (valid) pulses++;
        end
        sel = 1'b0;
        check("clear_no_valid_after", 9'(pulses), 9'd0);
        bits = '0;
        run_window("post_clear_zeros", bits, 0, 0, 1'b0);

        // Asynchronous reset between edges, mid-window
        bits = '1;
        run_window("pre_reset", bits, 0, 256, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        sel = 1'b1; bitin = 1'b1;
        repeat (30) tick();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_busy", 9'(busy), 9'd0);
        check("async_rst_valid", 9'(valid), 9'd0);
        check("async_rst_value", value, 9'd0);
        #1 rst = 1'b0;
        sel = 1'b0;
        tick();
        run_window("post_reset", bits, 0, 256, 1'b0);

        // Back-to-back: new start accepted in the oValid cycle
        for (int k = 0; k < N; k++) bits[k] = (k < 64);
        run_window("b2b_first", bits, 0, 64, 1'b1);
        bits = '1;
        run_window("b2b_second", bits, 0, 256, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
